// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
// Contents: RV32I width/sign codes, FSM state encodings, word width, and
// helpers that classify a request as legal or misaligned.
package lsu_pkg;

    localparam int unsigned WORD_W = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef logic [2:0] lsu_state_e;

    localparam lsu_state_e StIdle  = 3'd0;
    localparam lsu_state_e StLoad  = 3'd1;
    localparam lsu_state_e StRmwRd = 3'd2;
    localparam lsu_state_e StWrite = 3'd3;
    localparam lsu_state_e StResp  = 3'd4;

    // Stores have no unsigned variants; loads accept B/H/W/BU/HU.
    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        if (we) begin
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        end
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

    // f3[1:0] encodes size: 01 half, 10 word.
    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
        return ((f3[1:0] == 2'b01) && a[0]) || ((f3[1:0] == 2'b10) && (a != 2'b00));
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane logic for the load/store unit.
// Ports:
//   word_i   : word read from memory
//   addr_i   : byte offset within the word
//   funct3_i : RV32I width/sign code
//   wdata_i  : right-aligned store data
//   load_o   : selected lane, sign- or zero-extended
//   merge_o  : memory word with the store lane replaced (SW: wdata_i)
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [WORD_W-1:0] word_i,
    input  logic [1:0]        addr_i,
    input  logic [2:0]        funct3_i,
    input  logic [WORD_W-1:0] wdata_i,
    output logic [WORD_W-1:0] load_o,
    output logic [WORD_W-1:0] merge_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        sext;
    logic        unused_wdata;

    assign unused_wdata = ^wdata_i[31:16];

    always_comb begin
        byte_sel = word_i[{addr_i, 3'b000} +: 8];
        half_sel = addr_i[1] ? word_i[31:16] : word_i[15:0];
        // funct3[2] set marks the unsigned variants.
        sext     = ~funct3_i[2];
        load_o   = word_i;
        merge_o  = wdata_i;
        case (funct3_i[1:0])
            2'b00: begin
                load_o  = {{24{byte_sel[7] & sext}}, byte_sel};
                merge_o = word_i;
                merge_o[{addr_i, 3'b000} +: 8] = wdata_i[7:0];
            end
            2'b01: begin
                load_o  = {{16{half_sel[15] & sext}}, half_sel};
                merge_o = word_i;
                if (addr_i[1]) begin
                    merge_o[31:16] = wdata_i[15:0];
                end else begin
                    merge_o[15:0] = wdata_i[15:0];
                end
            end
            default: begin
                load_o  = word_i;
                merge_o = wdata_i;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Core-side load/store unit for a word-wide data memory.
// One request per valid/ready handshake; sub-word stores use read-modify-write.
// Configuration: define MISALIGN_TRAP_EN to report misaligned half/word accesses
// as errors; otherwise the low address bits are forced aligned.
// Ports:
//   clk_i, reset_n_i             : clock, async active-low reset
//   req_*                        : request handshake, we, funct3, byte addr, store data
//   rsp_*                        : response handshake, load data, error flag
//   mem_read_o, mem_write_o      : memory enables (never both high)
//   mem_addr_o, mem_wdata_o      : word index and write word
//   mem_rdata_i                  : combinational memory read data
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 64,
    parameter int unsigned ADDR_W      = 32
) (
    input  logic              clk_i,
    input  logic              reset_n_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [2:0]        req_funct3_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [WORD_W-1:0] req_wdata_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [WORD_W-1:0] rsp_rdata_o,
    output logic              rsp_err_o,
    output logic              mem_read_o,
    output logic              mem_write_o,
    output logic [WORD_W-1:0] mem_addr_o,
    output logic [WORD_W-1:0] mem_wdata_o,
    input  logic [WORD_W-1:0] mem_rdata_i
);

    localparam int unsigned IdxW = $clog2(DEPTH_WORDS);

    lsu_state_e        state_q, state_d;
    logic [2:0]        f3_q, f3_d;
    logic [IdxW+1:0]   addr_q, addr_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    logic [WORD_W-1:0] merge_q, merge_d;
    logic [WORD_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;

    logic [IdxW+1:0]   addr_lo;
    logic              bad;
    logic [WORD_W-1:0] load_val;
    logic [WORD_W-1:0] merge_val;
    logic              unused_addr;

    // Address bits above the word index wrap and are ignored.
    assign unused_addr = ^req_addr_i;

    lsu_lane_align u_lane_align (
        .word_i   (mem_rdata_i),
        .addr_i   (addr_q[1:0]),
        .funct3_i (f3_q),
        .wdata_i  (wdata_q),
        .load_o   (load_val),
        .merge_o  (merge_val)
    );

    always_comb begin
        addr_lo = req_addr_i[IdxW+1:0];
        bad     = ~f3_legal(req_we_i, req_funct3_i);
`ifdef MISALIGN_TRAP_EN
        bad = bad | misaligned(req_funct3_i, req_addr_i[1:0]);
`else
        if (req_funct3_i[1:0] == 2'b01) begin
            addr_lo[0] = 1'b0;
        end else if (req_funct3_i[1:0] == 2'b10) begin
            addr_lo[1:0] = 2'b00;
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        f3_d    = f3_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        merge_d = merge_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            StIdle: begin
                if (req_valid_i) begin
                    f3_d    = req_funct3_i;
                    addr_d  = addr_lo;
                    wdata_d = req_wdata_i;
                    merge_d = req_wdata_i;
                    rdata_d = '0;
                    err_d   = bad;
                    if (bad) begin
                        state_d = StResp;
                    end else if (!req_we_i) begin
                        state_d = StLoad;
                    end else if (req_funct3_i == F3_W) begin
                        state_d = StWrite;
                    end else begin
                        state_d = StRmwRd;
                    end
                end
            end
            StLoad: begin
                rdata_d = load_val;
                state_d = StResp;
            end
            StRmwRd: begin
                merge_d = merge_val;
                state_d = StWrite;
            end
            StWrite: begin
                state_d = StResp;
            end
            StResp: begin
                if (rsp_ready_i) begin
                    rdata_d = '0;
                    err_d   = 1'b0;
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= StIdle;
            f3_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            merge_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            merge_q <= merge_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Ready is masked by reset so every output reads 0 while reset is held.
    assign req_ready_o = reset_n_i && (state_q == StIdle);
    assign mem_read_o  = (state_q == StLoad) || (state_q == StRmwRd);
    assign mem_write_o = (state_q == StWrite);
    assign mem_addr_o  = (mem_read_o || mem_write_o) ?
                         {{(WORD_W - IdxW){1'b0}}, addr_q[IdxW+1:2]} : '0;
    assign mem_wdata_o = mem_write_o ? merge_q : '0;
    assign rsp_valid_o = (state_q == StResp);
    assign rsp_rdata_o = rsp_valid_o ? rdata_q : '0;
    assign rsp_err_o   = rsp_valid_o && err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed testbench for load_store_unit with a 64-word behavioural memory.
module tb_load_store_unit;

    logic        clk;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem [64];
    logic        fill_en;
    logic        poke_en;
    logic [5:0]  poke_idx;
    logic [31:0] poke_val;

    int n_chk;
    int n_fail;
    int lat;
    int rd_cnt;
    int wr_cnt;
    int both_cnt;
    logic [31:0] wr_addr;

    load_store_unit #(
        .DEPTH_WORDS (64),
        .ADDR_W      (32)
    ) dut (
        .clk_i        (clk),
        .reset_n_i    (reset_n),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_we_i     (req_we),
        .req_funct3_i (req_funct3),
        .req_addr_i   (req_addr),
        .req_wdata_i  (req_wdata),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_rdata_o  (rsp_rdata),
        .rsp_err_o    (rsp_err),
        .mem_read_o   (mem_read),
        .mem_write_o  (mem_write),
        .mem_addr_o   (mem_addr),
        .mem_wdata_o  (mem_wdata),
        .mem_rdata_i  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[5:0]];

    always @(posedge clk) begin
        if (fill_en) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'hEEEEEEEE;
        end else if (poke_en) begin
            mem[poke_idx] <= poke_val;
        end else if (mem_write) begin
            mem[mem_addr[5:0]] <= mem_wdata;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one request, wait for the response, optionally stall it, then retire it.
    task automatic xact(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] exp_rdata,
                        input logic exp_err, input int exp_lat, input int hold);
        logic got;
        @(negedge clk);
        check("req_ready_idle", {63'b0, req_ready}, 64'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        rsp_ready  = 1'b0;
        rd_cnt = 0; wr_cnt = 0; both_cnt = 0; lat = 0; got = 1'b0; wr_addr = '0;
        @(posedge clk);
        while (!got && lat < 20) begin
            @(negedge clk);
            req_valid = 1'b0;
            lat++;
            if (mem_read) rd_cnt++;
            if (mem_write) begin
                wr_cnt++;
                wr_addr = mem_addr;
            end
            if (mem_read && mem_write) both_cnt++;
            if (rsp_valid) got = 1'b1;
        end
        check("rsp_valid_seen", {63'b0, got}, 64'd1);
        check("latency", lat, exp_lat);
        check("rsp_rdata", rsp_rdata, exp_rdata);
        check("rsp_err", {63'b0, rsp_err}, {63'b0, exp_err});
        check("no_rd_wr_overlap", both_cnt, 0);
        repeat (hold) begin
            @(negedge clk);
            check("resp_hold", {rsp_valid, req_ready, mem_read, mem_write, rsp_rdata},
                  {1'b1, 1'b0, 1'b0, 1'b0, exp_rdata});
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        check("idle_after_resp", {rsp_valid, req_ready}, {1'b0, 1'b1});
    endtask

    task automatic fill_mem();
        @(negedge clk);
        fill_en = 1'b1;
        @(negedge clk);
        fill_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        n_chk = 0; n_fail = 0;
        reset_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0;
        req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
        fill_en = 1'b0; poke_en = 1'b0; poke_idx = '0; poke_val = '0;
        #3;
        check("reset_outputs",
              {req_ready, rsp_valid, rsp_err, mem_read, mem_write, rsp_rdata},
              {5'b0, 32'h0});
        check("reset_addr_wdata", {mem_addr, mem_wdata}, 64'h0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // 1: word store then load back
        xact(1'b1, 3'b010, 32'h8, 32'h12345678, 32'h0, 1'b0, 2, 0);
        check("sw_write_cycles", wr_cnt, 1);
        check("sw_write_addr", wr_addr, 32'd2);
        check("sw_no_read", rd_cnt, 0);
        xact(1'b0, 3'b010, 32'h8, 32'h0, 32'h12345678, 1'b0, 2, 0);
        check("lw_read_cycles", rd_cnt, 1);

        // 2: byte store into filled memory
        fill_mem();
        xact(1'b1, 3'b000, 32'h9, 32'h000000A5, 32'h0, 1'b0, 3, 0);
        check("sb_rmw_read", rd_cnt, 1);
        check("sb_write", wr_cnt, 1);
        check("sb_write_addr", wr_addr, 32'd2);
        xact(1'b0, 3'b010, 32'h8, 32'h0, 32'hEEEEA5EE, 1'b0, 2, 0);
        xact(1'b0, 3'b000, 32'h9, 32'h0, 32'hFFFFFFA5, 1'b0, 2, 0);
        xact(1'b0, 3'b100, 32'h9, 32'h0, 32'h000000A5, 1'b0, 2, 0);

        // 3: half store upper half
        xact(1'b1, 3'b001, 32'hE, 32'h00008001, 32'h0, 1'b0, 3, 0);
        xact(1'b0, 3'b001, 32'hE, 32'h0, 32'hFFFF8001, 1'b0, 2, 0);
        xact(1'b0, 3'b101, 32'hE, 32'h0, 32'h00008001, 1'b0, 2, 0);
        xact(1'b0, 3'b010, 32'hC, 32'h0, 32'h8001EEEE, 1'b0, 2, 0);

        // 4: misaligned word load and illegal funct3
        @(negedge clk);
        poke_en = 1'b1; poke_idx = 6'd1; poke_val = 32'hCAFEF00D;
        @(negedge clk);
        poke_en = 1'b0;
`ifdef MISALIGN_TRAP_EN
        xact(1'b0, 3'b010, 32'h6, 32'h0, 32'h0, 1'b1, 1, 0);
        check("misalign_no_read", rd_cnt, 0);
`else
        xact(1'b0, 3'b010, 32'h6, 32'h0, 32'hCAFEF00D, 1'b0, 2, 0);
        check("misalign_forced_read", rd_cnt, 1);
`endif
        xact(1'b0, 3'b011, 32'h8, 32'h0, 32'h0, 1'b1, 1, 0);
        check("illegal_no_access", rd_cnt + wr_cnt, 0);
        xact(1'b1, 3'b100, 32'h8, 32'h55, 32'h0, 1'b1, 1, 0);
        check("illegal_store_no_write", wr_cnt, 0);

        // 5: response backpressure
        xact(1'b0, 3'b010, 32'hC, 32'h0, 32'h8001EEEE, 1'b0, 2, 5);

        // 6: reset during the write cycle of a byte store
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000;
        req_addr = 32'h10; req_wdata = 32'h33;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("rst6_rmw_read", {63'b0, mem_read}, 64'd1);
        @(negedge clk);
        check("rst6_write_cycle", {mem_write, mem_addr}, {1'b1, 32'd4});
        #1;
        reset_n = 1'b0;
        #1;
        check("rst6_outputs_zero",
              {req_ready, rsp_valid, rsp_err, mem_read, mem_write, rsp_rdata},
              {5'b0, 32'h0});
        check("rst6_addr_wdata_zero", {mem_addr, mem_wdata}, 64'h0);
        @(posedge clk);
        @(negedge clk);
        check("rst6_word_unchanged", {32'h0, mem[4]}, {32'h0, 32'hEEEEEEEE});
        reset_n = 1'b1;
        #1;
        check("rst6_ready_after_release", {63'b0, req_ready}, 64'd1);
        xact(1'b0, 3'b010, 32'h10, 32'h0, 32'hEEEEEEEE, 1'b0, 2, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
